trap_unit: RTL and testbench

- Parametrised trap/interrupt controller; successor to the fixed three-interrupt (timer/software/external) handling and privilege-mode register currently owned by the datapath top.
- Supports NUM_IRQ sources, with a per-source level/edge mode selected by parameter.
- Arbitrates synchronous exceptions, interrupts and MRET.
- Drains the pipeline before taking an interrupt, then produces a single-cycle commit: redirect plus CSR write bundle. Sits beside the memory/writeback stages.

---
 rtl/trap_unit.sv | 167 ++++++++++++++++
 tb/tb_trap_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// M-mode trap/interrupt arbiter: exceptions commit one cycle after exc_valid, interrupts one cycle after pipe_idle.
// hold stalls fetch while an interrupt waits for the pipeline to drain; a single-cycle commit pulse carries redirect + CSR bundle.
module trap_unit #(
  parameter int                 XLEN      = 64,
  parameter int                 NUM_IRQ   = 3,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_clr,
  input  logic [NUM_IRQ-1:0] mie,
  input  logic [XLEN-1:0]    mstatus_in,
  input  logic [XLEN-1:0]    mtvec_in,
  input  logic [XLEN-1:0]    mepc_in,
  input  logic               exc_valid,
  input  logic [5:0]         exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret,
  input  logic               pipe_idle,
  input  logic [XLEN-1:0]    next_pc,
  output logic               hold,
  output logic               commit_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               csr_we,
  output logic [XLEN-1:0]    mepc_out,
  output logic [XLEN-1:0]    mcause_out,
  output logic [XLEN-1:0]    mtval_out,
  output logic [XLEN-1:0]    mstatus_out,
  output logic [1:0]         priv_mode,
  output logic [NUM_IRQ-1:0] mip_out
);

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP, RET} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] eligible;
  logic [3:0]         irq_idx;
  logic [3:0]         win_idx;
  logic               still_elig;
  logic               irq_en;
  logic [1:0]         next_priv;
  logic               take_irq;
  logic               do_trap;
  logic               do_ret;
  logic [5:0]         t_code;
  logic [XLEN-1:0]    t_epc;
  logic [XLEN-1:0]    t_cause;
  logic [XLEN-1:0]    t_tval;
  logic [XLEN-1:0]    t_redirect;
  logic [XLEN-1:0]    t_mstatus;
  logic [XLEN-1:0]    r_mstatus;
  logic [XLEN-1:0]    vec_off;

  // Edge sources latch until cleared; a fresh edge wins over a same-cycle clear.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i])
        pend_nxt[i] = (irq_in[i] & ~irq_prev[i]) | (mip_out[i] & ~irq_clr[i]);
      else
        pend_nxt[i] = irq_in[i];
    end
  end

  assign irq_en   = (priv_mode != 2'd3) | mstatus_in[3];
  assign eligible = irq_en ? (mip_out & mie) : '0;

  always_comb begin
    win_idx    = '0;
    still_elig = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = 4'(i);
      if (eligible[i] && irq_idx == 4'(i)) still_elig = 1'b1;
    end
  end

  // An exception always overrides the interrupt, so exc_valid alone names the trap source.
  assign take_irq = !exc_valid;
  assign do_trap  = ((state == IDLE) && exc_valid) ||
                    ((state == DRAIN) && (exc_valid || pipe_idle));
  assign do_ret   = (state == IDLE) && !exc_valid && mret;

  always_comb begin
    t_code  = take_irq ? {irq_idx, 2'b11} : exc_cause;
    t_epc   = take_irq ? next_pc : exc_pc;
    t_tval  = take_irq ? '0 : exc_tval;
    t_cause = '0;
    t_cause[5:0]      = t_code;
    t_cause[XLEN-1]   = take_irq;
    vec_off = '0;
    if (take_irq && mtvec_in[1:0] == 2'b01) vec_off[7:0] = {t_code, 2'b00};
    t_redirect = {mtvec_in[XLEN-1:2], 2'b00} + vec_off;
    t_mstatus         = mstatus_in;
    t_mstatus[7]      = mstatus_in[3];
    t_mstatus[3]      = 1'b0;
    t_mstatus[12:11]  = priv_mode;
    r_mstatus         = mstatus_in;
    r_mstatus[3]      = mstatus_in[7];
    r_mstatus[7]      = 1'b1;
    r_mstatus[12:11]  = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= 1'b0;
      commit_valid <= 1'b0;
      csr_we       <= 1'b0;
      redirect_pc  <= '0;
      mepc_out     <= '0;
      mcause_out   <= '0;
      mtval_out    <= '0;
      mstatus_out  <= '0;
      priv_mode    <= 2'd3;
      next_priv    <= 2'd3;
      mip_out      <= '0;
      irq_prev     <= '0;
      irq_idx      <= '0;
    end else begin
      mip_out      <= pend_nxt;
      irq_prev     <= irq_in;
      hold         <= 1'b0;
      commit_valid <= do_trap | do_ret;
      csr_we       <= do_trap | do_ret;
      redirect_pc  <= do_trap ? t_redirect : (do_ret ? mepc_in : '0);
      mepc_out     <= do_trap ? {t_epc[XLEN-1:2], 2'b00} : (do_ret ? mepc_in : '0);
      mcause_out   <= do_trap ? t_cause : '0;
      mtval_out    <= do_trap ? t_tval : '0;
      mstatus_out  <= do_trap ? t_mstatus : (do_ret ? r_mstatus : '0);
      case (state)
        IDLE: begin
          if (do_trap) begin
            state     <= TRAP;
            next_priv <= 2'd3;
          end else if (do_ret) begin
            state     <= RET;
            next_priv <= mstatus_in[12:11];
          end else if (|eligible) begin
            state   <= DRAIN;
            hold    <= 1'b1;
            irq_idx <= win_idx;
          end
        end
        DRAIN: begin
          if (do_trap) begin
            state     <= TRAP;
            next_priv <= 2'd3;
          end else if (!still_elig) begin
            state <= IDLE;
          end else begin
            hold <= 1'b1;
          end
        end
        // Privilege switches as the commit cycle retires, so the commit bundle saw the old mode.
        default: begin
          priv_mode <= next_priv;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
// Directed test-plan scenarios followed by a randomized run, all checked against a transaction-level reference model.
module tb_trap_unit;
  localparam int         XLEN    = 64;
  localparam int         NUM_IRQ = 3;
  localparam logic [2:0] EMASK   = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in, irq_clr, mie;
  logic [63:0] mstatus_in, mtvec_in, mepc_in, exc_pc, exc_tval, next_pc;
  logic        exc_valid, mret, pipe_idle;
  logic [5:0]  exc_cause;
  logic        hold, commit_valid, csr_we;
  logic [63:0] redirect_pc, mepc_out, mcause_out, mtval_out, mstatus_out;
  logic [1:0]  priv_mode;
  logic [2:0]  mip_out;

  trap_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .EDGE_MASK(EMASK)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_clr(irq_clr), .mie(mie),
    .mstatus_in(mstatus_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .pipe_idle(pipe_idle), .next_pc(next_pc),
    .hold(hold), .commit_valid(commit_valid), .redirect_pc(redirect_pc), .csr_we(csr_we),
    .mepc_out(mepc_out), .mcause_out(mcause_out), .mtval_out(mtval_out),
    .mstatus_out(mstatus_out), .priv_mode(priv_mode), .mip_out(mip_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending set, privilege, and whether a drain or commit is in progress.
  logic [2:0]  m_pend, m_prev;
  logic [1:0]  m_priv, m_next_priv;
  bit          m_drain, m_commit;
  int          m_idx;
  logic        e_hold, e_cv;
  logic [63:0] e_redirect, e_mepc, e_mcause, e_mtval, e_mstatus;
  logic [1:0]  e_priv;
  logic [2:0]  e_mip;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] trap_status(input logic [63:0] ms, input logic [1:0] p);
    return (ms & ~64'h1888) | (64'(ms[3]) << 7) | (64'(p) << 11);
  endfunction

  function automatic logic [63:0] ret_status(input logic [63:0] ms);
    return (ms & ~64'h1888) | (64'(ms[7]) << 3) | 64'h80;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_prev = 0; m_priv = 3; m_next_priv = 3; m_drain = 0; m_commit = 0; m_idx = 0;
    e_hold = 0; e_cv = 0; e_redirect = 0; e_mepc = 0; e_mcause = 0; e_mtval = 0; e_mstatus = 0;
    e_priv = 3; e_mip = 0;
  endtask

  task automatic model_step();
    logic [2:0]  elig;
    logic [63:0] base;
    int          win;
    int          code;
    elig = (m_priv != 2'd3 || mstatus_in[3]) ? (m_pend & mie) : 3'b000;
    win  = -1;
    for (int i = 2; i >= 0; i--) if (elig[i]) win = i;
    base = mtvec_in & ~64'h3;
    e_hold = 0; e_cv = 0; e_redirect = 0; e_mepc = 0; e_mcause = 0; e_mtval = 0; e_mstatus = 0;
    e_priv = m_priv;
    if (m_commit) begin
      e_priv = m_next_priv;
      m_commit = 0;
    end else if (exc_valid) begin
      e_cv = 1; e_redirect = base; e_mepc = exc_pc & ~64'h3;
      e_mcause = 64'(exc_cause); e_mtval = exc_tval;
      e_mstatus = trap_status(mstatus_in, m_priv);
      m_next_priv = 3; m_drain = 0; m_commit = 1;
    end else if (!m_drain && mret) begin
      e_cv = 1; e_redirect = mepc_in; e_mepc = mepc_in;
      e_mstatus = ret_status(mstatus_in);
      m_next_priv = mstatus_in[12:11]; m_commit = 1;
    end else if (!m_drain && win >= 0) begin
      m_drain = 1; e_hold = 1; m_idx = win;
    end else if (m_drain && pipe_idle) begin
      code = 4 * m_idx + 3;
      e_cv = 1;
      e_redirect = base + ((mtvec_in[1:0] == 2'b01) ? 64'(4 * code) : 64'd0);
      e_mepc = next_pc & ~64'h3;
      e_mcause = (64'h1 << 63) | 64'(code);
      e_mstatus = trap_status(mstatus_in, m_priv);
      m_next_priv = 3; m_drain = 0; m_commit = 1;
    end else if (m_drain && !elig[m_idx]) begin
      m_drain = 0;
    end else if (m_drain) begin
      e_hold = 1;
    end
    for (int i = 0; i < 3; i++)
      m_pend[i] = EMASK[i] ? ((irq_in[i] & ~m_prev[i]) | (m_pend[i] & ~irq_clr[i])) : irq_in[i];
    m_prev = irq_in;
    e_mip  = m_pend;
    m_priv = e_priv;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".hold"},    64'(hold),         64'(e_hold));
    chk({tag, ".cv"},      64'(commit_valid), 64'(e_cv));
    chk({tag, ".csr_we"},  64'(csr_we),       64'(e_cv));
    chk({tag, ".redir"},   redirect_pc,       e_redirect);
    chk({tag, ".mepc"},    mepc_out,          e_mepc);
    chk({tag, ".mcause"},  mcause_out,        e_mcause);
    chk({tag, ".mtval"},   mtval_out,         e_mtval);
    chk({tag, ".mstatus"}, mstatus_out,       e_mstatus);
    chk({tag, ".priv"},    64'(priv_mode),    64'(e_priv));
    chk({tag, ".mip"},     64'(mip_out),      64'(e_mip));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic quiet_inputs();
    irq_in = 0; irq_clr = 0; mie = 0; mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
    exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; mret = 0; pipe_idle = 0; next_pc = 0;
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    rst = 1'b0;

    // Synchronous exception from M-mode
    mtvec_in = 64'h8000_1000; mstatus_in = 64'h8;
    exc_valid = 1; exc_cause = 6'd2; exc_pc = 64'h8000_0010; exc_tval = 64'hDEAD;
    cyc("exc");
    chk("exc.redir_lit", redirect_pc, 64'h8000_1000);
    chk("exc.mcause_lit", mcause_out, 64'd2);
    chk("exc.mpp_mie", 64'({mstatus_out[12:11], mstatus_out[3]}), 64'b110);
    exc_valid = 0;
    cyc("exc_done");

    // MRET to U-mode
    mstatus_in = 64'h80; mepc_in = 64'h8000_0100; mret = 1;
    cyc("mret");
    chk("mret.redir_lit", redirect_pc, 64'h8000_0100);
    chk("mret.mie_lit", 64'(mstatus_out[3]), 64'd1);
    mret = 0;
    cyc("mret_done");
    chk("mret.priv_lit", 64'(priv_mode), 64'd0);

    // Vectored interrupt from U-mode, drain held for three cycles
    mstatus_in = 0; mtvec_in = 64'h8000_1001; mie = 3'b010; irq_in = 3'b010;
    next_pc = 64'h8000_0204;
    cyc("vec0");
    for (int i = 0; i < 3; i++) begin
      cyc("vec_drain");
      chk("vec.hold_lit", 64'(hold), 64'd1);
    end
    pipe_idle = 1;
    cyc("vec_commit");
    chk("vec.mcause_lit", mcause_out, 64'h8000_0000_0000_0007);
    chk("vec.redir_lit", redirect_pc, 64'h8000_101C);
    pipe_idle = 0; irq_in = 0;
    cyc("vec_done");
    chk("vec.priv_lit", 64'(priv_mode), 64'd3);

    // Masking by mstatus.MIE in M-mode
    mstatus_in = 0; mie = 3'b010; irq_in = 3'b010;
    for (int i = 0; i < 3; i++) cyc("mask");
    chk("mask.hold_lit", 64'(hold), 64'd0);
    mstatus_in = 64'h8;
    cyc("unmask");
    chk("unmask.hold_lit", 64'(hold), 64'd1);
    irq_in = 0;
    repeat (2) cyc("unmask_drop");

    // Priority: edge irq0 and level irq2 together
    mtvec_in = 64'h8000_2000; mie = 3'b101; irq_in = 3'b101;
    cyc("prio0");
    irq_in = 3'b100;
    cyc("prio1");
    pipe_idle = 1;
    cyc("prio_commit");
    chk("prio.mcause_lit", mcause_out, 64'h8000_0000_0000_0003);
    pipe_idle = 0; irq_in = 0; irq_clr = 3'b001; mie = 0;
    repeat (2) cyc("prio_done");
    irq_clr = 0;

    // Exception preempts a drain in progress
    mie = 3'b100; irq_in = 3'b100;
    repeat (2) cyc("pre_drain");
    exc_valid = 1; exc_cause = 6'd5; exc_pc = 64'h8000_0333; exc_tval = 64'h55;
    cyc("preempt");
    chk("preempt.mcause_lit", mcause_out, 64'd5);
    exc_valid = 0; irq_in = 0;
    repeat (3) cyc("preempt_done");

    // Edge latch, clear, and set-beats-clear
    mie = 0; irq_in = 3'b001;
    cyc("edge_pulse");
    irq_in = 0;
    repeat (3) cyc("edge_hold");
    chk("edge.latched_lit", 64'(mip_out[0]), 64'd1);
    irq_clr = 3'b001;
    cyc("edge_clr");
    chk("edge.cleared_lit", 64'(mip_out[0]), 64'd0);
    irq_in = 3'b001;
    cyc("edge_setclr");
    chk("edge.setwins_lit", 64'(mip_out[0]), 64'd1);
    irq_clr = 0; irq_in = 0;
    cyc("edge_done");

    // Reset while draining from U-mode
    mstatus_in = 64'h80; mret = 1;
    cyc("r_mret");
    mret = 0; mstatus_in = 0;
    cyc("r_mret_done");
    mie = 3'b100; irq_in = 3'b100;
    repeat (2) cyc("r_drain");
    #2 rst = 1'b1;
    #1;
    chk("rst.hold_lit", 64'(hold), 64'd0);
    chk("rst.priv_lit", 64'(priv_mode), 64'd3);
    quiet_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outs("rst_rel");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      exc_valid  = ($urandom_range(0, 9) == 0);
      exc_cause  = 6'($urandom_range(0, 63));
      exc_pc     = {$urandom, $urandom};
      exc_tval   = {$urandom, $urandom};
      mret       = ($urandom_range(0, 15) == 0);
      pipe_idle  = ($urandom_range(0, 2) == 0);
      next_pc    = {$urandom, $urandom};
      mepc_in    = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
        irq_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 15) == 0) mie = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) mstatus_in = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) mtvec_in = ({$urandom, $urandom} & ~64'h3) | 64'($urandom_range(0, 1));
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
